// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
// No logic; no latency.
// No flow control; definitions only.
package uart_loader_pkg;

    // Frame parser states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    // Default frame start marker.
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Width of the LEN field carried in the frame header.
    localparam int LEN_WIDTH = 16;

endpackage

// File: rtl/uart_loader_timeout.sv
// Inter-byte idle counter for the program loader.
// expired is combinational in the cycle the count would reach TIMEOUT_CYCLES.
// No flow control; clear has priority over expiry.
module uart_loader_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // The final idle cycle is flagged so the parser enters ERROR on the edge
    // where the count would reach TIMEOUT_CYCLES. A strobe in that same cycle
    // (clear) suppresses the expiry.
    assign expired = enable && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

    // Count idle cycles while enabled; any strobe or leaving the frame restarts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || !enable || expired) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Parses framed load commands from UART bytes and writes 32-bit words to instruction memory.
// mem_we, load_done and load_err appear one cycle after the triggering rx_done strobe.
// No back-pressure: every rx_done strobe is consumed, including back-to-back strobes.
module uart_program_loader
    import uart_loader_pkg::*;
#(
    parameter int         ADDR_WIDTH     = 10,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic       HOLD_ON_RESET  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_done,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err
);

    // Largest legal word count is the full memory depth.
    localparam logic [LEN_WIDTH:0] MAX_WORDS = (LEN_WIDTH + 1)'(2 ** ADDR_WIDTH);

    state_t                 state;
    state_t                 next_state;
    logic [7:0]             len_lo;
    logic [LEN_WIDTH-1:0]   len_full;
    logic [LEN_WIDTH-1:0]   words_left;
    logic [1:0]             byte_cnt;
    logic [23:0]            word_lo;
    logic [7:0]             checksum;
    logic [ADDR_WIDTH-1:0]  addr_cnt;
    logic                   in_frame;
    logic                   expired;
    logic                   len_too_big;
    logic                   sync_hit;

    assign len_full    = {rx_data, len_lo};
    assign len_too_big = {1'b0, len_full} > MAX_WORDS;
    assign sync_hit    = (state == ST_IDLE) && rx_done && (rx_data == SYNC_BYTE);
    assign in_frame    = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                         (state == ST_DATA)   || (state == ST_CHECK);

    uart_loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (rx_done),
        .enable (in_frame),
        .expired(expired)
    );

    // Parser state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: a strobe always takes precedence over timeout expiry.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (sync_hit) next_state = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (rx_done)      next_state = ST_LEN_HI;
                else if (expired) next_state = ST_ERROR;
            end
            ST_LEN_HI: begin
                if (rx_done) begin
                    if (len_too_big)          next_state = ST_ERROR;
                    else if (len_full == '0)  next_state = ST_CHECK;
                    else                      next_state = ST_DATA;
                end else if (expired) begin
                    next_state = ST_ERROR;
                end
            end
            ST_DATA: begin
                if (rx_done) begin
                    if (byte_cnt == 2'd3 && words_left == LEN_WIDTH'(1)) next_state = ST_CHECK;
                end else if (expired) begin
                    next_state = ST_ERROR;
                end
            end
            ST_CHECK: begin
                if (rx_done)      next_state = (rx_data == checksum) ? ST_DONE : ST_ERROR;
                else if (expired) next_state = ST_ERROR;
            end
            ST_DONE:  next_state = ST_IDLE;
            ST_ERROR: next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Datapath: header capture, word assembly, memory write and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_hold   <= HOLD_ON_RESET;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            len_lo     <= '0;
            words_left <= '0;
            byte_cnt   <= '0;
            word_lo    <= '0;
            checksum   <= '0;
            addr_cnt   <= '0;
        end else begin
            mem_we    <= 1'b0;
            load_done <= 1'b0;

            if (sync_hit) begin
                load_err <= 1'b0;
                checksum <= '0;
                cpu_hold <= 1'b1;
                addr_cnt <= '0;
                byte_cnt <= '0;
            end

            if (state == ST_LEN_LO && rx_done) len_lo <= rx_data;
            if (state == ST_LEN_HI && rx_done) words_left <= len_full;

            if (state == ST_DATA && rx_done) begin
                checksum <= checksum ^ rx_data;
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0: word_lo[7:0]   <= rx_data;
                    2'd1: word_lo[15:8]  <= rx_data;
                    2'd2: word_lo[23:16] <= rx_data;
                    default: begin
                        mem_wdata  <= {rx_data, word_lo};
                        mem_addr   <= addr_cnt;
                        mem_we     <= 1'b1;
                        addr_cnt   <= addr_cnt + ADDR_WIDTH'(1);
                        words_left <= words_left - LEN_WIDTH'(1);
                    end
                endcase
            end

            if (state == ST_CHECK && next_state == ST_DONE) begin
                load_done <= 1'b1;
                cpu_hold  <= 1'b0;
            end

            // cpu_hold deliberately stays high after an error.
            if (next_state == ST_ERROR) load_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: directed cases plus random frames.
// Outputs are sampled on the falling edge, one half-cycle after the DUT updates.
// Bytes are driven at the falling edge, back-to-back or with random idle gaps.
module tb_uart_program_loader;

    localparam int AW = 4;
    localparam int TO = 50;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_done;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_err;

    always #5 clk = ~clk;

    uart_program_loader #(
        .ADDR_WIDTH    (AW),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TO),
        .HOLD_ON_RESET (1'b0)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .load_done(load_done),
        .load_err (load_err)
    );

    int             n_checks = 0;
    int             n_fail   = 0;
    int             done_cnt = 0;
    logic [AW+31:0] got_q[$];
    logic [AW+31:0] exp_q[$];
    logic [7:0]     frame_q[$];
    logic           exp_err;
    int             exp_done;

    // Record every memory write and load_done pulse seen by the memory side.
    always @(negedge clk) begin
        if (mem_we)    got_q.push_back({mem_addr, mem_wdata});
        if (load_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    // Reference: derive the expected writes and outcome straight from the frame bytes.
    task automatic model_frame();
        int          len;
        logic [7:0]  x;
        logic [31:0] w;
        exp_q.delete();
        exp_err  = 1'b0;
        exp_done = 0;
        len = int'(frame_q[1]) + 256 * int'(frame_q[2]);
        if (len > (1 << AW)) begin
            exp_err = 1'b1;
            return;
        end
        x = 8'h00;
        for (int k = 0; k < len; k++) begin
            w = {frame_q[3+4*k+3], frame_q[3+4*k+2], frame_q[3+4*k+1], frame_q[3+4*k]};
            x = x ^ frame_q[3+4*k] ^ frame_q[3+4*k+1] ^ frame_q[3+4*k+2] ^ frame_q[3+4*k+3];
            exp_q.push_back({AW'(k), w});
        end
        if (frame_q[3+4*len] == x) exp_done = 1;
        else                       exp_err  = 1'b1;
    endtask

    task automatic build_frame(input int len, input bit good_chk);
        logic [7:0] x;
        logic [7:0] b;
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(len));
        frame_q.push_back(8'(len >> 8));
        if (len > (1 << AW)) return;
        x = 8'h00;
        for (int i = 0; i < 4 * len; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            frame_q.push_back(b);
        end
        if (good_chk) frame_q.push_back(x);
        else          frame_q.push_back(x ^ 8'(1 + $urandom_range(0, 254)));
    endtask

    task automatic run_frame(input string tag, input bit gaps);
        int gb;
        int db;
        idle(3);
        gb = got_q.size();
        db = done_cnt;
        model_frame();
        foreach (frame_q[i]) begin
            send_byte(frame_q[i]);
            if (gaps) idle($urandom_range(0, 3));
        end
        idle(3);
        check({tag, " nwrites"}, 64'(got_q.size() - gb), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (gb + i < got_q.size())
                check($sformatf("%s write%0d", tag, i), 64'(got_q[gb+i]), 64'(exp_q[i]));
        end
        check({tag, " load_done"}, 64'(done_cnt - db), 64'(exp_done));
        check({tag, " load_err"}, 64'(load_err), 64'(exp_err));
        check({tag, " cpu_hold"}, 64'(cpu_hold), 64'(exp_err));
    endtask

    initial begin
        int gb;
        reset   = 1'b1;
        rx_done = 1'b0;
        rx_data = 8'h00;
        idle(2);
        check("rst mem_we", 64'(mem_we), 64'd0);
        check("rst mem_addr", 64'(mem_addr), 64'd0);
        check("rst mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst cpu_hold", 64'(cpu_hold), 64'd0);
        check("rst load_done", 64'(load_done), 64'd0);
        check("rst load_err", 64'(load_err), 64'd0);
        reset = 1'b0;
        idle(2);

        // Happy path with back-to-back strobes and cycle-exact output checks.
        send_byte(8'hA5);
        check("happy cpu_hold rise", 64'(cpu_hold), 64'd1);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34);
        check("happy early we", 64'(mem_we), 64'd0);
        send_byte(8'h12);
        check("happy we0", 64'(mem_we), 64'd1);
        check("happy addr0", 64'(mem_addr), 64'd0);
        check("happy data0", 64'(mem_wdata), 64'h12345678);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        check("happy we1", 64'(mem_we), 64'd1);
        check("happy addr1", 64'(mem_addr), 64'd1);
        check("happy data1", 64'(mem_wdata), 64'hDEADBEEF);
        send_byte(8'h2A);
        check("happy load_done", 64'(load_done), 64'd1);
        check("happy cpu_hold fall", 64'(cpu_hold), 64'd0);
        check("happy load_err", 64'(load_err), 64'd0);
        idle(1);
        check("happy done pulse", 64'(load_done), 64'd0);

        // Reset between bytes 2 and 3 of a word aborts with no write.
        idle(2);
        gb = got_q.size();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        reset = 1'b1;
        @(negedge clk);
        check("midrst mem_we", 64'(mem_we), 64'd0);
        check("midrst mem_addr", 64'(mem_addr), 64'd0);
        check("midrst mem_wdata", 64'(mem_wdata), 64'd0);
        check("midrst cpu_hold", 64'(cpu_hold), 64'd0);
        check("midrst load_err", 64'(load_err), 64'd0);
        reset = 1'b0;
        idle(1);
        send_byte(8'h33); send_byte(8'h44);
        idle(3);
        check("midrst no write", 64'(got_q.size() - gb), 64'd0);
        check("midrst idle hold", 64'(cpu_hold), 64'd0);

        // Bad checksum.
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                    8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h5A};
        run_frame("badchk", 1'b0);

        // Zero length.
        frame_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame("zerolen", 1'b0);

        // Sync bytes inside the payload are data.
        frame_q = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'h01, 8'hA4};
        run_frame("midsync", 1'b0);

        // Overlength: error one cycle after the LEN_HI strobe.
        idle(3);
        gb = got_q.size();
        send_byte(8'hA5); send_byte(8'h11);
        check("overlen err early", 64'(load_err), 64'd0);
        send_byte(8'h00);
        check("overlen err", 64'(load_err), 64'd1);
        idle(3);
        check("overlen no write", 64'(got_q.size() - gb), 64'd0);
        check("overlen cpu_hold", 64'(cpu_hold), 64'd1);

        // Full-depth load ends on the top word.
        build_frame(1 << AW, 1'b1);
        run_frame("fulldepth", 1'b0);

        // Timeout: error exactly TO cycles after the last strobe.
        idle(3);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        idle(TO - 1);
        check("timeout early", 64'(load_err), 64'd0);
        idle(1);
        check("timeout err", 64'(load_err), 64'd1);
        check("timeout cpu_hold", 64'(cpu_hold), 64'd1);
        build_frame(3, 1'b1);
        run_frame("after timeout", 1'b1);

        // Random frames with random inter-byte gaps.
        for (int f = 0; f < 10; f++) begin
            build_frame($urandom_range(0, (1 << AW) + 2), $urandom_range(0, 3) != 0);
            run_frame($sformatf("rand%0d", f), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
